// File: rtl/pkt_filter_mc_if.sv
// AXI-Stream bundle used for the ingress and both egress ports of pkt_filter_mc.
// Master drives payload/valid, slave drives ready.
interface pkt_filter_mc_if #(
   parameter int DW = 512,
   parameter int TW = 128
) ();
   logic [DW-1:0]   tdata;
   logic [DW/8-1:0] tkeep;
   logic [TW-1:0]   tuser;
   logic            tvalid;
   logic            tlast;
   logic            tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_filter_mc.sv
// Ingress classifier: first beat picks DATA (m_axis), CONTROL (c_m_axis) or DROP; 1-cycle registered egress.
// Ingress stalls only while the packet's own egress stage is full and not being drained; DROP never stalls.
module pkt_filter_mc #(
   parameter int          C_S_AXIS_DATA_WIDTH  = 512,
   parameter int          C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [15:0] CTRL_PORT            = 16'hf1f2,
   parameter logic [15:0] CTRL_PORT_MASK       = 16'hffff,
   parameter int          CNT_WIDTH            = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pkt_filter_mc_if.slave       s_axis,
   pkt_filter_mc_if.master      m_axis,
   pkt_filter_mc_if.master      c_m_axis,
   input  logic                 cfg_pass_non_udp,
   output logic [CNT_WIDTH-1:0] stat_data_cnt,
   output logic [CNT_WIDTH-1:0] stat_ctrl_cnt,
   output logic [CNT_WIDTH-1:0] stat_drop_cnt
);
   localparam int DW = C_S_AXIS_DATA_WIDTH;
   localparam int KW = DW / 8;
   localparam int TW = C_S_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_e;
   typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_DROP} cls_e;

   state_e r_state, w_state_nxt;
   cls_e   w_cls, w_tgt;
   logic   w_runt, w_udp, w_port_hit, w_s_rdy, w_acc;

   logic          r_m_vld, r_m_last, r_c_vld, r_c_last;
   logic [DW-1:0] r_m_dat, r_c_dat;
   logic [KW-1:0] r_m_keep, r_c_keep;
   logic [TW-1:0] r_m_user, r_c_user;
   logic [CNT_WIDTH-1:0] r_data_cnt, r_ctrl_cnt, r_drop_cnt;

   assign w_runt     = ~&s_axis.tkeep[41:0];
   assign w_udp      = (s_axis.tdata[143:128] == 16'h0008) && (s_axis.tdata[223:216] == 8'h11);
   assign w_port_hit = ((s_axis.tdata[335:320] ^ CTRL_PORT) & CTRL_PORT_MASK) == 16'h0000;

   always_comb begin
      w_cls = CLS_DROP;
      if (w_runt)                w_cls = CLS_DROP;
      else if (w_udp)            w_cls = w_port_hit ? CLS_CTRL : CLS_DATA;
      else if (cfg_pass_non_udp) w_cls = CLS_DATA;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Target is the live classification in IDLE, the latched class otherwise.
   always_comb begin
      w_state_nxt = r_state;
      w_tgt       = CLS_DROP;
      w_s_rdy     = 1'b0;
      case (r_state)
         IDLE:     w_tgt = w_cls;
         FWD_DATA: w_tgt = CLS_DATA;
         FWD_CTRL: w_tgt = CLS_CTRL;
         default:  w_tgt = CLS_DROP;
      endcase
      case (w_tgt)
         CLS_DATA: w_s_rdy = ~r_m_vld | m_axis.tready;
         CLS_CTRL: w_s_rdy = ~r_c_vld | c_m_axis.tready;
         default:  w_s_rdy = 1'b1;
      endcase
      if (rst || (r_state == IDLE && !s_axis.tvalid)) w_s_rdy = 1'b0;
      w_acc = s_axis.tvalid & w_s_rdy;
      if (w_acc) begin
         if (s_axis.tlast) begin
            w_state_nxt = IDLE;
         end else if (r_state == IDLE) begin
            case (w_cls)
               CLS_DATA: w_state_nxt = FWD_DATA;
               CLS_CTRL: w_state_nxt = FWD_CTRL;
               default:  w_state_nxt = DROP;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_m_vld  <= 1'b0;
         r_m_last <= 1'b0;
         r_m_dat  <= '0;
         r_m_keep <= '0;
         r_m_user <= '0;
      end else if (w_acc && w_tgt == CLS_DATA) begin
         r_m_vld  <= 1'b1;
         r_m_last <= s_axis.tlast;
         r_m_dat  <= s_axis.tdata;
         r_m_keep <= s_axis.tkeep;
         r_m_user <= s_axis.tuser;
      end else if (m_axis.tready) begin
         r_m_vld  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_c_vld  <= 1'b0;
         r_c_last <= 1'b0;
         r_c_dat  <= '0;
         r_c_keep <= '0;
         r_c_user <= '0;
      end else if (w_acc && w_tgt == CLS_CTRL) begin
         r_c_vld  <= 1'b1;
         r_c_last <= s_axis.tlast;
         r_c_dat  <= s_axis.tdata;
         r_c_keep <= s_axis.tkeep;
         r_c_user <= s_axis.tuser;
      end else if (c_m_axis.tready) begin
         r_c_vld  <= 1'b0;
      end
   end

   // Counters saturate at all-ones rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data_cnt <= '0;
         r_ctrl_cnt <= '0;
         r_drop_cnt <= '0;
      end else if (w_acc && r_state == IDLE) begin
         case (w_cls)
            CLS_DATA: if (~&r_data_cnt) r_data_cnt <= r_data_cnt + CNT_WIDTH'(1);
            CLS_CTRL: if (~&r_ctrl_cnt) r_ctrl_cnt <= r_ctrl_cnt + CNT_WIDTH'(1);
            default:  if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
         endcase
      end
   end

   assign s_axis.tready   = w_s_rdy;
   assign m_axis.tvalid   = r_m_vld;
   assign m_axis.tlast    = r_m_last;
   assign m_axis.tdata    = r_m_dat;
   assign m_axis.tkeep    = r_m_keep;
   assign m_axis.tuser    = r_m_user;
   assign c_m_axis.tvalid = r_c_vld;
   assign c_m_axis.tlast  = r_c_last;
   assign c_m_axis.tdata  = r_c_dat;
   assign c_m_axis.tkeep  = r_c_keep;
   assign c_m_axis.tuser  = r_c_user;
   assign stat_data_cnt   = r_data_cnt;
   assign stat_ctrl_cnt   = r_ctrl_cnt;
   assign stat_drop_cnt   = r_drop_cnt;
endmodule
